// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end: FSM encoding, decode-queue
// entry layout and PC alignment.
package fetch_pkg;

    localparam int ADDR_W     = 64;
    localparam int INSN_W     = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pred_pc;
    } fetch_entry_t;

    // Clear the two low bits so every fetch address is word aligned.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries toward decode. Flush empties the queue in one
// edge and overrides any push/pop in the same cycle. Pointers wrap naturally
// because DEPTH is a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push && !i_flush && (r_count != FULL_CNT);
    assign w_pop   = i_pop  && !i_flush && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

    // Entry storage: write the pushed entry at the write pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping, flush resets everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage. Keeps the fetch PC, issues one instruction request at
// a time, shows the returning instruction to the branch predictor and queues
// {pc, insn, predicted next pc} toward decode. Backend redirects flush the
// queue; a request already in flight at redirect time is drained and dropped.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [ADDR_W-1:0] o_imem_req_addr,
    input  logic              i_imem_resp_valid,
    input  logic [INSN_W-1:0] i_imem_resp_data,
    output logic [ADDR_W-1:0] o_bp_pc,
    output logic [INSN_W-1:0] o_bp_instruction,
    input  logic [ADDR_W-1:0] i_bp_next_pc,
    input  logic              i_bp_overwrite_pc,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_dec_valid,
    input  logic              i_dec_ready,
    output logic [ADDR_W-1:0] o_dec_pc,
    output logic [INSN_W-1:0] o_dec_insn,
    output logic [ADDR_W-1:0] o_dec_pred_pc
);

    localparam int                CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(QUEUE_DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_inflight_pc;

    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_resp_take;
    logic [ADDR_W-1:0]  w_npc;
    logic [ADDR_W-1:0]  w_bp_pc;
    logic [INSN_W-1:0]  w_bp_insn;
    logic               w_room;

    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic [CNT_W-1:0]   w_q_count;
    logic               w_q_full;
    logic               w_q_empty;
    logic               w_pop;

    // A new request may only go out when the response is guaranteed a slot.
    assign w_room      = !w_q_full && (w_q_count < CNT_MAX);
    assign w_req_fire  = w_req_valid && i_imem_req_ready;
    // A response is kept only in S_WAIT and only if no redirect kills it.
    assign w_resp_take = (r_state == S_WAIT) && i_imem_resp_valid && !i_redirect_valid;
    assign w_npc       = align_pc(i_bp_overwrite_pc ? i_bp_next_pc
                                                    : r_inflight_pc + ADDR_W'(INSN_BYTES));
    assign w_pop       = o_dec_valid && i_dec_ready;

    assign w_push_entry.pc      = r_inflight_pc;
    assign w_push_entry.insn    = i_imem_resp_data;
    assign w_push_entry.pred_pc = w_npc;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_push      (w_resp_take),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (i_redirect_valid),
        .o_head      (w_head),
        .o_count     (w_q_count),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a request accepted under a redirect is already stale.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = i_redirect_valid ? S_DRAIN : S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (i_imem_resp_valid) begin
                    w_state_nxt = S_REQ;
                end else if (i_redirect_valid) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (i_imem_resp_valid) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // FSM outputs: request handshake and predictor view of the fetch.
    always_comb begin
        w_req_valid = 1'b0;
        w_bp_pc     = r_pc;
        w_bp_insn   = '0;
        case (r_state)
            S_REQ: begin
                w_req_valid = w_room && !i_reset;
            end
            S_WAIT: begin
                w_bp_pc   = r_inflight_pc;
                w_bp_insn = i_imem_resp_data;
            end
            S_DRAIN: begin
                w_req_valid = 1'b0;
            end
            default: begin
                w_req_valid = 1'b0;
            end
        endcase
    end

    // Fetch PC: redirect beats the predictor's choice of next PC.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect_valid) begin
            r_pc <= align_pc(i_redirect_pc);
        end else if (w_resp_take) begin
            r_pc <= w_npc;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Remember the address of the single outstanding request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_inflight_pc <= RESET_PC;
        end else if (w_req_fire) begin
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight_pc <= r_inflight_pc;
        end
    end

    // Outputs are held at zero while reset is asserted.
    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = i_reset ? '0 : r_pc;
    assign o_bp_pc          = i_reset ? '0 : w_bp_pc;
    assign o_bp_instruction = i_reset ? '0 : w_bp_insn;
    assign o_dec_valid      = !w_q_empty && !i_reset;
    assign o_dec_pc         = o_dec_valid ? w_head.pc      : '0;
    assign o_dec_insn       = o_dec_valid ? w_head.insn    : '0;
    assign o_dec_pred_pc    = o_dec_valid ? w_head.pred_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, predicted jump, queue
// back-pressure, redirects (in flight and same-cycle), PC wrap and reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [63:0] bp_pc;
    logic [31:0] bp_instruction;
    logic [63:0] bp_next_pc;
    logic        bp_overwrite_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [63:0] dec_pc;
    logic [31:0] dec_insn;
    logic [63:0] dec_pred_pc;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;
    localparam logic [31:0] ADDI3 = 32'h0030_0193;
    localparam logic [31:0] ADDI4 = 32'h0040_0213;
    localparam logic [31:0] JAL   = 32'h0100_006F;

    fetch_unit #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (64'h1000)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .o_imem_req_valid  (imem_req_valid),
        .i_imem_req_ready  (imem_req_ready),
        .o_imem_req_addr   (imem_req_addr),
        .i_imem_resp_valid (imem_resp_valid),
        .i_imem_resp_data  (imem_resp_data),
        .o_bp_pc           (bp_pc),
        .o_bp_instruction  (bp_instruction),
        .i_bp_next_pc      (bp_next_pc),
        .i_bp_overwrite_pc (bp_overwrite_pc),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_pc     (redirect_pc),
        .o_dec_valid       (dec_valid),
        .i_dec_ready       (dec_ready),
        .o_dec_pc          (dec_pc),
        .o_dec_insn        (dec_insn),
        .o_dec_pred_pc     (dec_pred_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and checks happen at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // One complete fetch from S_REQ with a one-cycle response.
    task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data,
                            input logic ovr, input logic [63:0] npc);
        check_eq("req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_eq("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check_eq("req_valid_wait", {63'd0, imem_req_valid}, 64'd0);
        check_eq("bp_pc", bp_pc, addr);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        bp_overwrite_pc = ovr;
        bp_next_pc      = npc;
        #1;
        check_eq("bp_insn", {32'd0, bp_instruction}, {32'd0, data});
        step();
        imem_resp_valid = 1'b0;
        bp_overwrite_pc = 1'b0;
        bp_next_pc      = 64'd0;
        #1;
        check_eq("dec_valid_after_resp", {63'd0, dec_valid}, 64'd1);
    endtask

    logic [63:0] exp_pc   [4];
    logic [31:0] exp_insn [4];
    logic [63:0] exp_pred [4];

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        bp_next_pc      = 64'd0;
        bp_overwrite_pc = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'd0;
        dec_ready       = 1'b0;

        step();
        check_eq("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check_eq("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
        check_eq("rst_req_addr", imem_req_addr, 64'd0);
        check_eq("rst_bp_pc", bp_pc, 64'd0);
        reset = 1'b0;
        #1;

        // Sequential fetches and a predicted jump.
        do_fetch(64'h1000, ADDI1, 1'b0, 64'd0);
        check_eq("first_dec_pc", dec_pc, 64'h1000);
        check_eq("first_dec_pred", dec_pred_pc, 64'h1004);
        do_fetch(64'h1004, ADDI2, 1'b0, 64'd0);
        do_fetch(64'h1008, JAL, 1'b1, 64'h2000);
        check_eq("jal_next_addr", imem_req_addr, 64'h2000);
        do_fetch(64'h2000, ADDI3, 1'b0, 64'd0);

        // Queue full: no further request while decode stalls.
        check_eq("full_req_valid", {63'd0, imem_req_valid}, 64'd0);
        step();
        check_eq("full_req_valid_hold", {63'd0, imem_req_valid}, 64'd0);
        check_eq("full_head_pc", dec_pc, 64'h1000);

        // One pop frees one slot.
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        #1;
        check_eq("pop_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_eq("pop_req_addr", imem_req_addr, 64'h2004);
        check_eq("pop_head_pc", dec_pc, 64'h1004);
        do_fetch(64'h2004, ADDI4, 1'b0, 64'd0);
        check_eq("refull_req_valid", {63'd0, imem_req_valid}, 64'd0);

        // Drain in order.
        exp_pc[0] = 64'h1004; exp_insn[0] = ADDI2; exp_pred[0] = 64'h1008;
        exp_pc[1] = 64'h1008; exp_insn[1] = JAL;   exp_pred[1] = 64'h2000;
        exp_pc[2] = 64'h2000; exp_insn[2] = ADDI3; exp_pred[2] = 64'h2004;
        exp_pc[3] = 64'h2004; exp_insn[3] = ADDI4; exp_pred[3] = 64'h2008;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", {63'd0, dec_valid}, 64'd1);
            check_eq("drain_pc", dec_pc, exp_pc[i]);
            check_eq("drain_insn", {32'd0, dec_insn}, {32'd0, exp_insn[i]});
            check_eq("drain_pred", dec_pred_pc, exp_pred[i]);
            dec_ready = 1'b1;
            step();
        end
        dec_ready = 1'b0;
        #1;
        check_eq("drained_empty", {63'd0, dec_valid}, 64'd0);

        // Redirect while waiting: queue flushed, late response dropped.
        do_fetch(64'h2008, ADDI1, 1'b0, 64'd0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3002;
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("redir_flush", {63'd0, dec_valid}, 64'd0);
        check_eq("drain_no_req", {63'd0, imem_req_valid}, 64'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = ADDI2;
        step();
        imem_resp_valid = 1'b0;
        #1;
        check_eq("stale_dropped", {63'd0, dec_valid}, 64'd0);
        check_eq("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_eq("redir_req_addr", imem_req_addr, 64'h3000);

        // Redirect in the same cycle as the response: no drain.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = ADDI3;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h4000;
        step();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        #1;
        check_eq("same_cyc_no_push", {63'd0, dec_valid}, 64'd0);
        check_eq("same_cyc_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_eq("same_cyc_req_addr", imem_req_addr, 64'h4000);

        // Redirect to top of address space; sequential PC wraps to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC, ADDI1, 1'b0, 64'd0);
        check_eq("wrap_dec_pc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("wrap_pred", dec_pred_pc, 64'd0);
        check_eq("wrap_req_addr", imem_req_addr, 64'd0);

        // Reset in the middle of a wait.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("midrst_dec_valid", {63'd0, dec_valid}, 64'd0);
        check_eq("midrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("postrst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_eq("postrst_req_addr", imem_req_addr, 64'h1000);
        check_eq("postrst_dec_valid", {63'd0, dec_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
